// File: rtl/trace_arb_pkg.sv
// Shared constants and types for the packet-granular trace char arbiter.
package trace_arb_pkg;

  localparam logic [7:0] CH_START = 8'h5E;
  localparam logic [7:0] CH_END   = 8'h23;
  localparam logic [7:0] CH_ABORT = 8'h21;

  typedef enum logic {ST_IDLE, ST_LOCK} arb_state_e;

  // Advance a source index, wrapping at the number of populated sources.
  function automatic logic [1:0] wrap_inc(input logic [1:0] idx, input int unsigned n);
    return ((32'(idx) + 32'd1) >= n) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/trace_char_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/trace_char_arbiter.sv
// Merges up to four per-core trace char streams into one, locking on a source
// from its leading '^' to its '#', draining junk and aborting stalled packets.
module trace_char_arbiter
  import trace_arb_pkg::*;
#(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [7:0]  ABORT_CHAR = CH_ABORT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SRC-1:0]     src_valid,
  input  logic [8*N_SRC-1:0]   src_char,
  output logic [N_SRC-1:0]     src_ready,
  output logic                 out_valid,
  output logic [7:0]           out_char,
  output logic [1:0]           grant_id,
  output logic                 locked,
  output logic                 pkt_done,
  output logic                 abort
);

  localparam int unsigned CNT_W = 8;

  arb_state_e       state, state_nxt;
  logic [1:0]       rr_ptr, rr_nxt, grant_nxt;
  logic [CNT_W-1:0] idle_cnt, cnt_nxt;
  logic             out_valid_nxt, pkt_done_nxt, abort_nxt, locked_nxt;
  logic [7:0]       out_char_nxt;
  logic [3:0]       valid4, start4, ready_c;
  logic [7:0]       char4 [4];
  logic             pick_found;
  logic [1:0]       pick_idx;
  logic             owner_valid;
  logic [7:0]       owner_char;

  // Pad the source vectors to four lanes; absent lanes never request.
  for (genvar g = 0; g < 4; g++) begin : g_pad
    if (g < N_SRC) begin : g_src
      assign valid4[g] = src_valid[g];
      assign char4[g]  = src_char[8*g +: 8];
    end else begin : g_none
      assign valid4[g] = 1'b0;
      assign char4[g]  = 8'h00;
    end
    assign start4[g] = valid4[g] && (char4[g] == CH_START);
  end

  rr_pick u_pick (
    .req   (start4),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_valid = valid4[grant_id];
  assign owner_char  = char4[grant_id];
  assign src_ready   = reset ? '0 : ready_c[N_SRC-1:0];

  always_comb begin
    state_nxt     = state;
    rr_nxt        = rr_ptr;
    cnt_nxt       = idle_cnt;
    grant_nxt     = grant_id;
    out_valid_nxt = 1'b0;
    out_char_nxt  = out_char;
    pkt_done_nxt  = 1'b0;
    abort_nxt     = 1'b0;
    ready_c       = '0;
    unique case (state)
      ST_IDLE: begin
        // Non-start chars are drained; losing '^' candidates wait.
        ready_c = valid4 & ~start4;
        if (pick_found) begin
          ready_c[pick_idx] = 1'b1;
          out_valid_nxt     = 1'b1;
          out_char_nxt      = CH_START;
          grant_nxt         = pick_idx;
          cnt_nxt           = '0;
          state_nxt         = ST_LOCK;
        end
      end
      ST_LOCK: begin
        ready_c[grant_id] = owner_valid;
        if (owner_valid) begin
          out_valid_nxt = 1'b1;
          out_char_nxt  = owner_char;
          cnt_nxt       = '0;
          if (owner_char == CH_END) begin
            pkt_done_nxt = 1'b1;
            rr_nxt       = wrap_inc(grant_id, N_SRC);
            state_nxt    = ST_IDLE;
          end
        end else if (idle_cnt == CNT_W'(TIMEOUT - 1)) begin
          out_valid_nxt = 1'b1;
          out_char_nxt  = ABORT_CHAR;
          abort_nxt     = 1'b1;
          cnt_nxt       = '0;
          rr_nxt        = wrap_inc(grant_id, N_SRC);
          state_nxt     = ST_IDLE;
        end else begin
          cnt_nxt = idle_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    locked_nxt = (state_nxt == ST_LOCK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= 2'd0;
      idle_cnt  <= '0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      grant_id  <= 2'd0;
      locked    <= 1'b0;
      pkt_done  <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      idle_cnt  <= cnt_nxt;
      out_valid <= out_valid_nxt;
      out_char  <= out_char_nxt;
      grant_id  <= grant_nxt;
      locked    <= locked_nxt;
      pkt_done  <= pkt_done_nxt;
      abort     <= abort_nxt;
    end
  end

endmodule
